// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, control-field encoding and stage-register layout
// for the 5-stage pipeline bypass datapath.
package pipe_pkg;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int CTRL_W     = 4;
    localparam int CTRL_ALU   = 3;
    localparam int CTRL_IMM   = 2;
    localparam int CTRL_MEM   = 1;
    localparam int CTRL_WRITE = 0;
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
    // a/b carry the rs/rt operands in E, result/store data in M, result/load data in W
    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } stage_t;
    localparam stage_t BUBBLE = '{valid: 1'b0, ctrl: CTRL_NOP, dst: '0, pc: '0, a: '0, b: '0};
    function automatic logic is_load(input logic [CTRL_W-1:0] c);
        return c[CTRL_MEM] & ~c[CTRL_WRITE];
    endfunction
    function automatic logic is_store(input logic [CTRL_W-1:0] c);
        return c[CTRL_MEM] & c[CTRL_WRITE];
    endfunction
endpackage

// File: rtl/operand_bypass_mux.sv
// operand_bypass_mux: 3:1 priority forwarding mux; the M-stage value wins
// over W because it belongs to the younger producer.
module operand_bypass_mux
    import pipe_pkg::*;
(
    input  logic              m_sel_i,
    input  logic              w_sel_i,
    input  logic [DATA_W-1:0] m_val_i,
    input  logic [DATA_W-1:0] w_val_i,
    input  logic [DATA_W-1:0] lat_val_i,
    output logic [DATA_W-1:0] val_o
);
    assign val_o = m_sel_i ? m_val_i : w_sel_i ? w_val_i : lat_val_i;
endmodule

// File: rtl/pipe_stage_bypass_datapath.sv
// pipe_stage_bypass_datapath: F/D, D/E, E/M and M/W stage registers with
// stall/flush handling and operand/store-data forwarding.
module pipe_stage_bypass_datapath
    import pipe_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   w_stall,
    input  logic                   w_flush,
    input  logic                   w_me_rs_bypass,
    input  logic                   w_me_rt_bypass,
    input  logic                   w_we_rs_bypass,
    input  logic                   w_we_rt_bypass,
    input  logic                   w_wm_rt_bypass,
    input  logic                   w_fetch_valid,
    input  logic [DATA_W-1:0]      w_fetch_pc_32,
    input  logic [DATA_W-1:0]      w_fetch_insn_32,
    input  logic [DATA_W-1:0]      w_rs_data_32,
    input  logic [DATA_W-1:0]      w_rt_data_32,
    input  logic [CTRL_W-1:0]      w_dec_ctrl_4,
    input  logic [ADDR_W-1:0]      w_dec_dst_addr_5,
    input  logic [DATA_W-1:0]      w_alu_result_32,
    input  logic [DATA_W-1:0]      w_mem_rdata_32,
    output logic                   w_pc_hold,
    output logic                   w_d_valid,
    output logic [DATA_W-1:0]      w_d_pc_32,
    output logic [DATA_W-1:0]      w_d_insn_32,
    output logic                   w_e_valid,
    output logic [CTRL_W-1:0]      w_e_ctrl_4,
    output logic [ADDR_W-1:0]      w_e_dst_addr_5,
    output logic [DATA_W-1:0]      w_e_rs_val_32,
    output logic [DATA_W-1:0]      w_e_rt_val_32,
    output logic                   w_m_valid,
    output logic [CTRL_W-1:0]      w_m_ctrl_4,
    output logic [ADDR_W-1:0]      w_m_dst_addr_5,
    output logic [DATA_W-1:0]      w_m_result_32,
    output logic [DATA_W-1:0]      w_m_store_data_32,
    output logic                   w_wb_en,
    output logic [ADDR_W-1:0]      w_wb_regfile_addr_5,
    output logic [DATA_W-1:0]      w_wb_data_32,
    output logic [STALL_CNT_W-1:0] w_stall_cnt_16
);
    logic                   d_valid_q, d_valid_d;
    logic [DATA_W-1:0]      d_pc_q, d_pc_d, d_insn_q, d_insn_d;
    stage_t                 e_q, e_d, m_q, m_d, w_q, w_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   hold;
    logic [DATA_W-1:0]      rs_val, rt_val, st_val, wb_data;

    // flush dominates stall, so a flushed cycle never holds the PC
    assign hold = w_stall & ~w_flush;

    operand_bypass_mux u_rs_mux (
        .m_sel_i   (w_me_rs_bypass & e_q.valid),
        .w_sel_i   (w_we_rs_bypass & e_q.valid),
        .m_val_i   (m_q.a),
        .w_val_i   (wb_data),
        .lat_val_i (e_q.a),
        .val_o     (rs_val)
    );

    operand_bypass_mux u_rt_mux (
        .m_sel_i   (w_me_rt_bypass & e_q.valid),
        .w_sel_i   (w_we_rt_bypass & e_q.valid),
        .m_val_i   (m_q.a),
        .w_val_i   (wb_data),
        .lat_val_i (e_q.b),
        .val_o     (rt_val)
    );

    operand_bypass_mux u_st_mux (
        .m_sel_i   (1'b0),
        .w_sel_i   (w_wm_rt_bypass),
        .m_val_i   ('0),
        .w_val_i   (wb_data),
        .lat_val_i (m_q.b),
        .val_o     (st_val)
    );

    always_comb begin
        d_valid_d = w_flush ? 1'b0 : hold ? d_valid_q : w_fetch_valid;
        d_pc_d    = w_flush ? '0 : hold ? d_pc_q : w_fetch_pc_32;
        d_insn_d  = w_flush ? '0 : hold ? d_insn_q : w_fetch_insn_32;
        e_d       = (w_stall | w_flush | ~d_valid_q) ? BUBBLE
                  : {1'b1, w_dec_ctrl_4, w_dec_dst_addr_5, d_pc_q, w_rs_data_32, w_rt_data_32};
        m_d       = {e_q.valid, e_q.ctrl, e_q.dst, e_q.pc, w_alu_result_32, rt_val};
        w_d       = {m_q.valid, m_q.ctrl, m_q.dst, m_q.pc, m_q.a, w_mem_rdata_32};
        cnt_d     = (hold && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            d_valid_q <= 1'b0;
            d_pc_q    <= '0;
            d_insn_q  <= '0;
            e_q       <= BUBBLE;
            m_q       <= BUBBLE;
            w_q       <= BUBBLE;
            cnt_q     <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            d_pc_q    <= d_pc_d;
            d_insn_q  <= d_insn_d;
            e_q       <= e_d;
            m_q       <= m_d;
            w_q       <= w_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wb_data             = is_load(w_q.ctrl) ? w_q.b : w_q.a;
    assign w_pc_hold           = hold;
    assign w_d_valid           = d_valid_q;
    assign w_d_pc_32           = d_pc_q;
    assign w_d_insn_32         = d_insn_q;
    assign w_e_valid           = e_q.valid;
    assign w_e_ctrl_4          = e_q.ctrl;
    assign w_e_dst_addr_5      = e_q.dst;
    assign w_e_rs_val_32       = rs_val;
    assign w_e_rt_val_32       = rt_val;
    assign w_m_valid           = m_q.valid;
    assign w_m_ctrl_4          = m_q.ctrl;
    assign w_m_dst_addr_5      = m_q.dst;
    assign w_m_result_32       = m_q.a;
    assign w_m_store_data_32   = st_val;
    assign w_wb_en             = w_q.valid & (|w_q.dst) & ~is_store(w_q.ctrl);
    assign w_wb_regfile_addr_5 = w_q.dst;
    assign w_wb_data_32        = wb_data;
    assign w_stall_cnt_16      = cnt_q;
endmodule
